// File: rtl/spinner_quad_gen_pkg.sv
// Shared types and dial-code helpers for the joystick-driven spinner emulation.
package spinner_pkg;

  typedef enum logic {IDLE, RUN} spin_state_t;

  typedef enum logic [1:0] {DIR_NONE, DIR_INC, DIR_DEC} spin_dir_t;

  // Active-low Gray sequence indexed by phase; incrementing walks forward.
  localparam logic [1:0] QUAD_LUT [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

  localparam logic [1:0] DIAL_REST    = 2'b11;
  localparam logic [1:0] DIAL_LEG_INC = 2'b01;
  localparam logic [1:0] DIAL_LEG_DEC = 2'b10;

  function automatic logic [1:0] quad_code(input logic [1:0] phase);
    return QUAD_LUT[phase];
  endfunction

  // Both pressed or neither pressed means no rotation request.
  function automatic spin_dir_t decode_dir(input logic inc, input logic dec, input logic invert);
    logic up;
    logic dn;
    up = inc ^ invert;
    dn = dec ^ invert;
    if (up && !dn) return DIR_INC;
    if (dn && !up) return DIR_DEC;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/spinner_quad_gen_channel.sv
// One dial channel: IDLE/RUN control, step-period and acceleration counters,
// quadrature phase, signed position and the registered dial code.
module spinner_channel
  import spinner_pkg::*;
#(
  parameter int PERIOD_SLOW = 8,
  parameter int PERIOD_FAST = 2,
  parameter int ACCEL_HOLD  = 6,
  parameter int POS_W       = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             tick,
  input  logic             pause,
  input  logic             enable,
  input  logic             quad_mode,
  input  logic             invert,
  input  logic             inc,
  input  logic             dec,
  output logic [1:0]       dial_out,
  output logic [POS_W-1:0] pos,
  output logic             step
);

  localparam int PER_W = (PERIOD_SLOW > 1) ? $clog2(PERIOD_SLOW) : 1;
  localparam int ACC_W = (ACCEL_HOLD > 0) ? $clog2(ACCEL_HOLD + 1) : 1;

  spin_state_t      state, state_n;
  spin_dir_t        cur_dir, cur_dir_n, dir;
  logic [PER_W-1:0] period_cnt, period_n;
  logic [ACC_W-1:0] accel_cnt, accel_n;
  logic [1:0]       phase, phase_n;
  logic [POS_W-1:0] pos_n;
  logic             step_n;
  logic [1:0]       dial_n;

  assign dir = decode_dir(inc, dec, invert);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_dir    <= DIR_NONE;
      period_cnt <= '0;
      accel_cnt  <= '0;
      phase      <= '0;
      pos        <= '0;
      step       <= 1'b0;
      dial_out   <= DIAL_REST;
    end else if (pause) begin
      step <= 1'b0;
    end else begin
      state      <= state_n;
      cur_dir    <= cur_dir_n;
      period_cnt <= period_n;
      accel_cnt  <= accel_n;
      phase      <= phase_n;
      pos        <= pos_n;
      step       <= step_n;
      dial_out   <= dial_n;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    cur_dir_n = cur_dir;
    period_n  = period_cnt;
    accel_n   = accel_cnt;
    phase_n   = phase;
    pos_n     = pos;
    step_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && dir != DIR_NONE) begin
          state_n   = RUN;
          cur_dir_n = dir;
          period_n  = '0;
          accel_n   = '0;
        end
      end
      RUN: begin
        if (!enable || dir == DIR_NONE) begin
          state_n = IDLE;
        end else if (dir != cur_dir) begin
          // Reversal restarts the schedule: first reversed step on the next tick.
          cur_dir_n = dir;
          period_n  = '0;
          accel_n   = '0;
        end else if (tick) begin
          if (period_cnt == '0) begin
            step_n   = 1'b1;
            phase_n  = (cur_dir == DIR_INC) ? phase + 2'd1 : phase - 2'd1;
            pos_n    = (cur_dir == DIR_INC) ? pos + POS_W'(1) : pos - POS_W'(1);
            period_n = (accel_cnt >= ACC_W'(ACCEL_HOLD)) ? PER_W'(PERIOD_FAST - 1)
                                                          : PER_W'(PERIOD_SLOW - 1);
            if (accel_cnt < ACC_W'(ACCEL_HOLD)) accel_n = accel_cnt + ACC_W'(1);
          end else begin
            period_n = period_cnt - PER_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (!enable) phase_n = '0;
  end

  // Dial code is computed from next state so it lands together with phase/pos.
  always_comb begin
    dial_n = DIAL_REST;
    if (enable) begin
      if (quad_mode)
        dial_n = quad_code(phase_n);
      else if (state_n == RUN)
        dial_n = (cur_dir_n == DIR_INC) ? DIAL_LEG_INC : DIAL_LEG_DEC;
    end
  end

endmodule

// File: rtl/spinner_quad_gen.sv
// Rotary dial emulation for NUM_CH players: shared millisecond prescaler
// feeding one spinner_channel per player.
module spinner_quad_gen
  import spinner_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int TICK_DIV    = 12000,
  parameter int PERIOD_SLOW = 8,
  parameter int PERIOD_FAST = 2,
  parameter int ACCEL_HOLD  = 6,
  parameter int POS_W       = 8
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       quad_mode,
  input  logic [NUM_CH-1:0]       invert,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [NUM_CH-1:0]       dec,
  input  logic                    pause,
  output logic [2*NUM_CH-1:0]     dial_out,
  output logic [POS_W*NUM_CH-1:0] pos,
  output logic [NUM_CH-1:0]       step
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] pre_cnt;
  logic             tick;

  assign tick = !pause && (pre_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      pre_cnt <= '0;
    else if (!pause)
      pre_cnt <= tick ? '0 : pre_cnt + DIV_W'(1);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    spinner_channel #(
      .PERIOD_SLOW (PERIOD_SLOW),
      .PERIOD_FAST (PERIOD_FAST),
      .ACCEL_HOLD  (ACCEL_HOLD),
      .POS_W       (POS_W)
    ) u_ch (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .tick      (tick),
      .pause     (pause),
      .enable    (enable[c]),
      .quad_mode (quad_mode[c]),
      .invert    (invert[c]),
      .inc       (inc[c]),
      .dec       (dec[c]),
      .dial_out  (dial_out[2*c +: 2]),
      .pos       (pos[POS_W*c +: POS_W]),
      .step      (step[c])
    );
  end

endmodule
